ram_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (1-cycle registered read, write-first-blocks-read) between two requesters: port A (CPU data side) and port B (DMA/display fetch side).
- Grants at most one access per cycle, drives the RAM's wEn/addr/dataIn, and returns read data with a matching valid strobe to the winner.
- Sits between the core's memory stage / DMA engine and the RAM instance.

---
 rtl/ram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two requesters sharing one single-port synchronous RAM.
// Define ARB_ROUND_ROBIN_EN for alternating contention instead of fixed priority.
module ram_port_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     a_req,
   input  logic                     a_we,
   input  logic [ADDRESS_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0]    a_wdata,
   output logic                     a_gnt,
   output logic                     a_rvalid,
   output logic [DATA_WIDTH-1:0]    a_rdata,
   input  logic                     b_req,
   input  logic                     b_we,
   input  logic [ADDRESS_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0]    b_wdata,
   output logic                     b_gnt,
   output logic                     b_rvalid,
   output logic [DATA_WIDTH-1:0]    b_rdata,
   output logic                     ram_wEn,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_dataIn,
   input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

   logic                     sel_a;
   logic                     sel_b;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [ADDRESS_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic [DATA_WIDTH-1:0]    wdata_d;
   logic                     a_rvalid_q;
   logic                     b_rvalid_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_b_q;
   logic last_b_d;
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_q;
   logic [3:0] starve_d;
`endif

   always_comb begin
      sel_a = 1'b0;
      sel_b = 1'b0;
      if (rst_n) begin
         if (a_req && b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel_a = last_b_q;
            sel_b = ~last_b_q;
`else
            sel_b = (starve_q == LIMIT);
            sel_a = ~sel_b;
`endif
         end else begin
            sel_a = a_req;
            sel_b = b_req;
         end
      end
   end

   // Idle cycles replay the last granted address so RAM output stays put.
   always_comb begin
      ram_wEn = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (sel_a) begin
         ram_wEn = a_we;
         addr_d  = a_addr;
         wdata_d = a_wdata;
      end else if (sel_b) begin
         ram_wEn = b_we;
         addr_d  = b_addr;
         wdata_d = b_wdata;
      end
      ram_addr   = rst_n ? addr_d : '0;
      ram_dataIn = rst_n ? wdata_d : '0;
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      last_b_d = last_b_q;
      if (sel_a) last_b_d = 1'b0;
      if (sel_b) last_b_d = 1'b1;
   end
`else
   always_comb begin
      starve_d = '0;
      if (b_req && !sel_b)
         starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_b_q   <= 1'b1;
`else
         starve_q   <= '0;
`endif
      end else begin
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         a_rvalid_q <= sel_a & ~a_we;
         b_rvalid_q <= sel_b & ~b_we;
`ifdef ARB_ROUND_ROBIN_EN
         last_b_q   <= last_b_d;
`else
         starve_q   <= starve_d;
`endif
      end
   end

   assign a_gnt    = sel_a;
   assign b_gnt    = sel_b;
   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = ram_dataOut;
   assign b_rdata  = ram_dataOut;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed bench for ram_port_arbiter
// with a behavioural RAM and a scoreboard model of the arbitration rules.
module tb_ram_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          ram_wEn;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dataIn;
   logic [DW-1:0] ram_dataOut = '0;
   logic [DW-1:0] ram_arr [4096];

   ram_port_arbiter #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
      .ram_dataOut(ram_dataOut)
   );

   always #5 clk = ~clk;

   // Single-port RAM: a write leaves the read output untouched.
   always @(posedge clk) begin
      if (ram_wEn) ram_arr[ram_addr] <= ram_dataIn;
      else         ram_dataOut <= ram_arr[ram_addr];
   end

   int total = 0;
   int bad = 0;

   // Reference model state (winner codes: 0 none, 1 A, 2 B)
   logic [DW-1:0] mdl_mem [4096];
   int            m_wait;
   int            m_last;
   logic [AW-1:0] m_haddr;
   logic [DW-1:0] m_hdata;

   int            e_win;
   logic          e_av, e_bv, e_wen;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_din, e_rd;
   logic          o_ag, o_bg, o_wen, o_av, o_bv;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_din, o_ard, o_brd;

   function automatic int exp_win(input logic ar, input logic br);
      if (!ar && !br) return 0;
      if (ar && !br) return 1;
      if (!ar && br) return 2;
`ifdef ARB_ROUND_ROBIN_EN
      return (m_last == 1) ? 2 : 1;
`else
      return (m_wait >= SL) ? 2 : 1;
`endif
   endfunction

   task automatic model_reset();
      m_wait  = 0;
      m_last  = 2;
      m_haddr = '0;
      m_hdata = '0;
   endtask

   // Drive one cycle (called at posedge+1), sample, advance the model.
   task automatic go(input logic ar, input logic aw, input logic [AW-1:0] aa,
                     input logic [DW-1:0] ad, input logic br, input logic bw,
                     input logic [AW-1:0] ba, input logic [DW-1:0] bd);
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
      #3;
      o_ag = a_gnt; o_bg = b_gnt; o_wen = ram_wEn;
      o_addr = ram_addr; o_din = ram_dataIn;
      e_win = exp_win(ar, br);
      e_av = 1'b0; e_bv = 1'b0; e_wen = 1'b0;
      e_addr = m_haddr; e_din = m_hdata;
      if (e_win == 1) begin
         e_wen = aw; e_addr = aa; e_din = ad; e_av = !aw;
      end else if (e_win == 2) begin
         e_wen = bw; e_addr = ba; e_din = bd; e_bv = !bw;
      end
      if (e_win != 0) begin
         m_haddr = e_addr;
         m_hdata = e_din;
         m_last  = e_win;
         if (e_wen) mdl_mem[e_addr] = e_din;
         else       e_rd = mdl_mem[e_addr];
      end
      if (br && e_win != 2) m_wait = (m_wait < SL) ? m_wait + 1 : SL;
      else                  m_wait = 0;
      @(posedge clk); #1;
      o_av = a_rvalid; o_bv = b_rvalid; o_ard = a_rdata; o_brd = b_rdata;
   endtask

   task automatic idle();
      go(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_reset();
      a_req = 1'b1; a_we = 1'b1; a_addr = 12'h5A5; a_wdata = 32'hCAFE0001;
      b_req = 1'b1; b_we = 1'b1; b_addr = 12'h3C3; b_wdata = 32'hCAFE0002;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({a_gnt, b_gnt, ram_wEn} !== 3'b000) begin
         bad++;
         $display("FAIL reset_ctl got=%b want=000", {a_gnt, b_gnt, ram_wEn});
      end
      total++;
      if (ram_addr !== '0 || ram_dataIn !== '0) begin
         bad++;
         $display("FAIL reset_bus got addr=%h din=%h want 0", ram_addr, ram_dataIn);
      end
      @(posedge clk); #1;
      total++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_gnt !== 1'b0) begin
         bad++;
         $display("FAIL reset_rvalid got a=%b b=%b want 0", a_rvalid, b_rvalid);
      end
      a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      go(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
      total++;
      if (o_ag !== 1'b1 || o_wen !== 1'b1 || o_addr !== 12'h010 ||
          o_din !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL single_wr got gnt=%b we=%b addr=%h din=%h want 1 1 010 deadbeef",
                  o_ag, o_wen, o_addr, o_din);
      end
      go(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
      total++;
      if (o_ag !== 1'b1 || o_wen !== 1'b0) begin
         bad++;
         $display("FAIL single_rd_gnt got gnt=%b we=%b want 1 0", o_ag, o_wen);
      end
      total++;
      if (o_av !== 1'b1 || o_ard !== 32'hDEADBEEF || o_bv !== 1'b0) begin
         bad++;
         $display("FAIL single_rd_data got av=%b rd=%h bv=%b want 1 deadbeef 0",
                  o_av, o_ard, o_bv);
      end
   endtask

   task automatic test_contention();
      int first;
      int p;
      idle();
      first = (m_last == 1) ? 2 : 1;
      for (int i = 0; i < 15; i++) begin
         go(1'b1, 1'b0, AW'($urandom_range(0, 31)), '0,
            1'b1, 1'b0, AW'($urandom_range(0, 31)), '0);
`ifdef ARB_ROUND_ROBIN_EN
         p = (i % 2 == 0) ? first : 3 - first;
`else
         p = (i % 5 == 4) ? 2 : 1;
`endif
         total++;
         if (o_ag !== (p == 1) || o_bg !== (p == 2)) begin
            bad++;
            $display("FAIL contend_pat cyc=%0d got a=%b b=%b want winner %0d",
                     i, o_ag, o_bg, p);
         end
         total++;
         if (o_av !== e_av || o_bv !== e_bv ||
             (e_av && o_ard !== e_rd) || (e_bv && o_brd !== e_rd)) begin
            bad++;
            $display("FAIL contend_rd cyc=%0d got av=%b bv=%b rd=%h want %b %b %h",
                     i, o_av, o_bv, o_ard, e_av, e_bv, e_rd);
         end
      end
   endtask

   task automatic test_b_write_read();
      idle();
      go(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'hFFF, 32'h00000055);
      total++;
      if (o_bg !== 1'b1 || o_wen !== 1'b1 || o_addr !== 12'hFFF || o_bv !== 1'b0) begin
         bad++;
         $display("FAIL b_write got gnt=%b we=%b addr=%h bv=%b want 1 1 fff 0",
                  o_bg, o_wen, o_addr, o_bv);
      end
      go(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'hFFF, '0);
      total++;
      if (o_wen !== 1'b0 || o_bv !== 1'b1 || o_brd !== 32'h00000055 || o_av !== 1'b0) begin
         bad++;
         $display("FAIL b_read got we=%b bv=%b rd=%h av=%b want 0 1 00000055 0",
                  o_wen, o_bv, o_brd, o_av);
      end
   endtask

   task automatic test_idle_hold();
      go(1'b1, 1'b1, 12'h020, 32'h00001234, 1'b0, 1'b0, '0, '0);
      go(1'b1, 1'b0, 12'h020, '0, 1'b0, 1'b0, '0, '0);
      total++;
      if (o_av !== 1'b1 || o_ard !== 32'h00001234) begin
         bad++;
         $display("FAIL hold_rd got av=%b rd=%h want 1 00001234", o_av, o_ard);
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         total++;
         if (o_wen !== 1'b0 || o_addr !== 12'h020 || o_ard !== 32'h00001234 ||
             o_av !== 1'b0 || o_bv !== 1'b0 || o_ag !== 1'b0 || o_bg !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold cyc=%0d got we=%b addr=%h dout=%h av=%b bv=%b",
                     i, o_wen, o_addr, o_ard, o_av, o_bv);
         end
      end
   endtask

   task automatic test_random();
      logic ar, aw, br, bw;
      for (int i = 0; i < 300; i++) begin
         ar = 1'($urandom_range(0, 1));
         br = 1'($urandom_range(0, 1));
         aw = ($urandom_range(0, 3) == 0);
         bw = ($urandom_range(0, 3) == 0);
         go(ar, aw, AW'($urandom_range(0, 15)), $urandom,
            br, bw, AW'($urandom_range(0, 15)), $urandom);
         total++;
         if (o_ag !== (e_win == 1) || o_bg !== (e_win == 2)) begin
            bad++;
            $display("FAIL rand_gnt cyc=%0d got a=%b b=%b want winner %0d",
                     i, o_ag, o_bg, e_win);
         end
         total++;
         if (o_wen !== e_wen || o_addr !== e_addr || o_din !== e_din) begin
            bad++;
            $display("FAIL rand_bus cyc=%0d got we=%b addr=%h din=%h want %b %h %h",
                     i, o_wen, o_addr, o_din, e_wen, e_addr, e_din);
         end
         total++;
         if (o_av !== e_av || o_bv !== e_bv ||
             (e_av && o_ard !== e_rd) || (e_bv && o_brd !== e_rd)) begin
            bad++;
            $display("FAIL rand_rd cyc=%0d got av=%b bv=%b rd=%h want %b %b %h",
                     i, o_av, o_bv, o_ard, e_av, e_bv, e_rd);
         end
      end
   endtask

   task automatic test_async_reset();
      idle();
      a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010; a_wdata = '0;
      b_req = 1'b1; b_we = 1'b1; b_addr = 12'h010; b_wdata = 32'hBAD0BAD0;
      #3;
      total++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
         bad++;
         $display("FAIL arst_pre got a=%b b=%b want 1 0", a_gnt, b_gnt);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({a_gnt, b_gnt, ram_wEn} !== 3'b000 || ram_addr !== '0) begin
         bad++;
         $display("FAIL arst_comb got ctl=%b addr=%h want 000 000",
                  {a_gnt, b_gnt, ram_wEn}, ram_addr);
      end
      @(posedge clk); #1;
      total++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || ram_wEn !== 1'b0) begin
         bad++;
         $display("FAIL arst_rvalid got av=%b bv=%b we=%b want 0 0 0",
                  a_rvalid, b_rvalid, ram_wEn);
      end
      a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
      #2 rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      go(1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b0, 12'h020, '0);
      total++;
      if (o_ag !== 1'b1 || o_bg !== 1'b0 || o_av !== 1'b1 || o_ard !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL arst_after got a=%b b=%b av=%b rd=%h want 1 0 1 deadbeef",
                  o_ag, o_bg, o_av, o_ard);
      end
      go(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h020, '0);
      total++;
      if (o_bg !== 1'b1 || o_bv !== 1'b1 || o_brd !== 32'h00001234) begin
         bad++;
         $display("FAIL arst_b got b=%b bv=%b rd=%h want 1 1 00001234",
                  o_bg, o_bv, o_brd);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram_arr[i] = '0;
         mdl_mem[i] = '0;
      end
      model_reset();
      e_rd = '0;
      test_reset();
      test_single_read();
      test_contention();
      test_b_write_read();
      test_idle_hold();
      test_async_reset();
      test_random();
      test_contention();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
